// File: rtl/instr_decode_seq.sv
// Sequencing decoder for the 9-bit basic processor ISA.
// Issues one-shot ALU/regfile/memory strobes and counts retired instructions.
module instr_decode_seq #(
  parameter int IW = 9,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] InstrIn,
  input  logic          InstrValid,
  output logic          InstrReady,
  input  logic          AccNZ,
  input  logic          MemAck,
  output logic [3:0]    AluOp,
  output logic [3:0]    RegAddr,
  output logic [DW-1:0] Imm,
  output logic          ImmSel,
  output logic          RegWrite,
  output logic          MemReq,
  output logic          MemWrite,
  output logic          BranchTaken,
  output logic          Illegal,
  output logic          Done,
  output logic [CW-1:0] RetireCnt
);

  localparam int OW = IW - 4;

  localparam logic [3:0] K_LSH  = 4'd0;
  localparam logic [3:0] K_RSH  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_LDI  = 4'd4;
  localparam logic [3:0] K_LDR  = 4'd5;
  localparam logic [3:0] K_STR  = 4'd6;
  localparam logic [3:0] K_BNZ  = 4'd7;
  localparam logic [3:0] K_GEQ  = 4'd8;
  localparam logic [3:0] K_EQ   = 4'd9;
  localparam logic [3:0] K_NEG  = 4'd10;
  localparam logic [3:0] K_ADD  = 4'd11;
  localparam logic [3:0] K_ADDI = 4'd12;
  localparam logic [3:0] K_NEQ  = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_EXE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_aluop;
  logic [3:0]       r_regaddr;
  logic [DW-1:0]    r_imm;
  logic             r_illegal;
  logic [CW-1:0]    r_cnt;

  logic [3:0]       w_op;
  logic [OW-1:0]    w_opnd;
  logic             w_accept;
  logic             w_halt;
  logic             w_bad;
  logic             w_mem;
  logic             w_legal;
  logic             w_retire;
  logic [DW-1:0]    w_imm;

  assign w_op     = InstrIn[IW-1:IW-4];
  assign w_opnd   = InstrIn[OW-1:0];
  assign w_accept = (r_state == S_DEC) && InstrValid;
  assign w_halt   = &InstrIn;
  assign w_bad    = (w_op[3:1] == 3'b111) && !w_halt;
  assign w_mem    = (w_op == K_LDR) || (w_op == K_STR);
  assign w_legal  = (r_aluop[3:1] != 3'b111);

  // Immediate extension chosen by the incoming opcode
  always_comb begin
    w_imm = '0;
    unique case (1'b1)
      (w_op == K_LDI):
        w_imm = {{(DW-OW){1'b0}}, w_opnd};
      (w_op == K_ADDI),
      (w_op == K_BNZ):
        w_imm = {{(DW-OW){w_opnd[OW-1]}}, w_opnd};
      default: w_imm = '0;
    endcase
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start) w_next = S_DEC;
      S_DEC: begin
        if (w_accept) begin
          if (w_halt)     w_next = S_HALT;
          else if (w_mem) w_next = S_MEM;
          else            w_next = S_EXE;
        end
      end
      S_EXE: w_next = S_DEC;
      S_MEM: begin
        if (MemAck)
          w_next = (r_aluop == K_STR) ? S_DEC : S_WB;
      end
      S_WB:   w_next = S_DEC;
      S_HALT: if (Start) w_next = S_DEC;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state register and latched word
  always_comb begin
    InstrReady  = 1'b0;
    Done        = 1'b0;
    RegWrite    = 1'b0;
    ImmSel      = 1'b0;
    BranchTaken = 1'b0;
    MemReq      = 1'b0;
    MemWrite    = 1'b0;
    case (r_state)
      S_DEC:  InstrReady = 1'b1;
      S_HALT: Done = 1'b1;
      S_EXE: begin
        RegWrite    = w_legal && (r_aluop != K_BNZ);
        ImmSel      = (r_aluop == K_LDI) ||
                      (r_aluop == K_ADDI) ||
                      (r_aluop == K_BNZ);
        BranchTaken = (r_aluop == K_BNZ) && AccNZ;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemWrite = (r_aluop == K_STR);
      end
      S_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  // Retirement points: EXE/WB exit, STR completion, HALT entry
  assign w_retire = ((r_state == S_EXE) && w_legal) ||
                    (r_state == S_WB) ||
                    ((r_state == S_MEM) && MemAck &&
                     (r_aluop == K_STR)) ||
                    (w_accept && w_halt);

  // State, latched fields, sticky flag and counter
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_aluop   <= '0;
      r_regaddr <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_aluop   <= w_op;
        r_regaddr <= w_opnd[3:0];
        r_imm     <= w_imm;
        if (w_bad) r_illegal <= 1'b1;
      end
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign AluOp     = r_aluop;
  assign RegAddr   = r_regaddr;
  assign Imm       = r_imm;
  assign Illegal   = r_illegal;
  assign RetireCnt = r_cnt;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Directed bench for instr_decode_seq with a 4-bit retire counter.
// Table of single-issue ops plus hand-built memory/halt/reset sequences.
module tb_instr_decode_seq;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [8:0] InstrIn;
  logic       InstrValid;
  logic       InstrReady;
  logic       AccNZ;
  logic       MemAck;
  logic [3:0] AluOp;
  logic [3:0] RegAddr;
  logic [7:0] Imm;
  logic       ImmSel;
  logic       RegWrite;
  logic       MemReq;
  logic       MemWrite;
  logic       BranchTaken;
  logic       Illegal;
  logic       Done;
  logic [3:0] RetireCnt;

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  always #5 Clk = ~Clk;

  instr_decode_seq #(.IW(9), .DW(8), .CW(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .AccNZ(AccNZ),
    .MemAck(MemAck), .AluOp(AluOp), .RegAddr(RegAddr),
    .Imm(Imm), .ImmSel(ImmSel), .RegWrite(RegWrite),
    .MemReq(MemReq), .MemWrite(MemWrite),
    .BranchTaken(BranchTaken), .Illegal(Illegal),
    .Done(Done), .RetireCnt(RetireCnt)
  );

  typedef struct {
    logic [8:0] instr;
    logic       accnz;
    logic [3:0] aluop;
    logic [3:0] regaddr;
    logic [7:0] imm;
    logic       immsel;
    logic       regwr;
    logic       br;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] w);
    chk("ready_before_issue", 32'(InstrReady), 1);
    InstrIn    = w;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
  endtask

  task automatic chk_cnt(input string n);
    chk(n, 32'(RetireCnt), 32'(exp_total % 16));
  endtask

  initial begin
    vecs[0] = '{9'b1100_11110, 1'b0, 4'hC, 4'hE, 8'hFE, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{9'b0100_10101, 1'b0, 4'h4, 4'h5, 8'h15, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{9'b1011_00010, 1'b0, 4'hB, 4'h2, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{9'b0111_10000, 1'b1, 4'h7, 4'h0, 8'hF0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{9'b0111_10000, 1'b0, 4'h7, 4'h0, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{9'b0111_00011, 1'b1, 4'h7, 4'h3, 8'h03, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{9'b0000_01001, 1'b0, 4'h0, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{9'b1101_11111, 1'b0, 4'hD, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0};

    Reset_n = 1'b0; Start = 1'b0; InstrIn = '0;
    InstrValid = 1'b0; AccNZ = 1'b0; MemAck = 1'b0;

    // reset held for two edges
    step(); step();
    chk("rst_ready", 32'(InstrReady), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_illegal", 32'(Illegal), 0);
    chk("rst_cnt", 32'(RetireCnt), 0);
    chk("rst_aluop", 32'(AluOp), 0);
    chk("rst_imm", 32'(Imm), 0);
    chk("rst_strobes",
        32'({RegWrite, MemReq, MemWrite, BranchTaken, ImmSel}), 0);
    Reset_n = 1'b1;
    step();
    chk("idle_ready", 32'(InstrReady), 0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("start_ready", 32'(InstrReady), 1);

    // Start in DEC is ignored
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("start_in_dec", 32'(InstrReady), 1);

    // table of single-EXE ops
    for (int i = 0; i < 8; i++) begin
      AccNZ = vecs[i].accnz;
      issue(vecs[i].instr);
      chk($sformatf("v%0d_ready", i), 32'(InstrReady), 0);
      chk($sformatf("v%0d_aluop", i), 32'(AluOp), 32'(vecs[i].aluop));
      chk($sformatf("v%0d_regaddr", i), 32'(RegAddr), 32'(vecs[i].regaddr));
      chk($sformatf("v%0d_imm", i), 32'(Imm), 32'(vecs[i].imm));
      chk($sformatf("v%0d_immsel", i), 32'(ImmSel), 32'(vecs[i].immsel));
      chk($sformatf("v%0d_regwr", i), 32'(RegWrite), 32'(vecs[i].regwr));
      chk($sformatf("v%0d_br", i), 32'(BranchTaken), 32'(vecs[i].br));
      chk($sformatf("v%0d_memreq", i), 32'(MemReq), 0);
      step();
      AccNZ = 1'b0;
      exp_total++;
      chk($sformatf("v%0d_regwr_off", i), 32'(RegWrite), 0);
      chk($sformatf("v%0d_br_off", i), 32'(BranchTaken), 0);
      chk($sformatf("v%0d_ready_back", i), 32'(InstrReady), 1);
      chk($sformatf("v%0d_imm_hold", i), 32'(Imm), 32'(vecs[i].imm));
      chk_cnt($sformatf("v%0d_cnt", i));
    end

    // LDR with ack on the third MEM cycle
    issue(9'b0101_00011);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ldr_memreq%0d", c), 32'(MemReq), 1);
      chk($sformatf("ldr_memwr%0d", c), 32'(MemWrite), 0);
      chk($sformatf("ldr_regaddr%0d", c), 32'(RegAddr), 3);
      chk($sformatf("ldr_regwr%0d", c), 32'(RegWrite), 0);
      if (c == 2) MemAck = 1'b1;
      step();
    end
    MemAck = 1'b0;
    chk("ldr_wb_regwr", 32'(RegWrite), 1);
    chk("ldr_wb_memreq", 32'(MemReq), 0);
    chk("ldr_wb_ready", 32'(InstrReady), 0);
    chk_cnt("ldr_wb_cnt");
    step();
    exp_total++;
    chk("ldr_done_ready", 32'(InstrReady), 1);
    chk("ldr_done_regwr", 32'(RegWrite), 0);
    chk_cnt("ldr_cnt");

    // STR acked in its first MEM cycle
    issue(9'b0110_00111);
    chk("str_memreq", 32'(MemReq), 1);
    chk("str_memwr", 32'(MemWrite), 1);
    chk("str_regaddr", 32'(RegAddr), 7);
    chk("str_regwr", 32'(RegWrite), 0);
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    exp_total++;
    chk("str_memreq_off", 32'(MemReq), 0);
    chk("str_regwr_off", 32'(RegWrite), 0);
    chk("str_ready", 32'(InstrReady), 1);
    chk_cnt("str_cnt");

    // stray MemAck in DEC
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    chk("stray_ack_ready", 32'(InstrReady), 1);
    chk("stray_ack_memreq", 32'(MemReq), 0);
    chk_cnt("stray_ack_cnt");

    // illegal opcode
    issue(9'b1110_00000);
    chk("ill_regwr", 32'(RegWrite), 0);
    chk("ill_immsel", 32'(ImmSel), 0);
    chk("ill_br", 32'(BranchTaken), 0);
    chk("ill_memreq", 32'(MemReq), 0);
    step();
    chk("ill_flag", 32'(Illegal), 1);
    chk("ill_ready", 32'(InstrReady), 1);
    chk_cnt("ill_cnt");

    // retire ADDs until 17 total; counter wraps to 1
    while (exp_total < 17) begin
      issue(9'b1011_00001);
      step();
      exp_total++;
    end
    chk("wrap_cnt", 32'(RetireCnt), 1);
    chk("ill_sticky", 32'(Illegal), 1);

    // HALT and restart
    issue(9'h1FF);
    exp_total++;
    chk("halt_done", 32'(Done), 1);
    chk("halt_ready", 32'(InstrReady), 0);
    chk_cnt("halt_cnt");
    step();
    chk("halt_hold", 32'(Done), 1);
    chk_cnt("halt_cnt_hold");
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("restart_done", 32'(Done), 0);
    chk("restart_ready", 32'(InstrReady), 1);
    chk("restart_illegal", 32'(Illegal), 1);

    // reset while waiting in MEM
    issue(9'b0101_00010);
    chk("mid_mem_req", 32'(MemReq), 1);
    Reset_n = 1'b0;
    step();
    chk("rst_mem_req", 32'(MemReq), 0);
    chk("rst_mem_ready", 32'(InstrReady), 0);
    chk("rst_mem_illegal", 32'(Illegal), 0);
    chk("rst_mem_cnt", 32'(RetireCnt), 0);
    Reset_n = 1'b1;
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    chk("post_rst_idle", 32'(InstrReady), 0);
    chk("post_rst_regwr", 32'(RegWrite), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_seq.md
Name: instr_decode_seq

Overview:
- Sequencing instruction decoder for the basic processor: the consumer of the 4-bit opcode map (kLSH..kNEQ).
- Accepts 9-bit instruction words from fetch over a valid/ready handshake.
- Decodes each word and drives registered one-shot control strobes to the ALU, register file and data memory.
- Stalls on a req/ack handshake for LDR/STR, resolves BNZ, detects HALT and illegal opcodes, and counts retired instructions.

Parameters:
- IW, 9, instruction width; opcode = instr[IW-1:IW-4], operand = instr[IW-5:0].
- DW, 8, datapath width for extended immediates and branch offsets.
- CW, 16, retired-instruction counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  pulse; leaves IDLE/HALT and begins decoding.
- InstrIn  in  IW  instruction word from fetch.
- InstrValid  in  1  InstrIn is valid.
- InstrReady  out  1  decoder accepts InstrIn this cycle.
- AccNZ  in  1  accumulator-nonzero flag from the datapath, sampled in EXE.
- MemAck  in  1  data-memory completion.
- AluOp  out  4  opcode forwarded to the ALU (definitions encoding).
- RegAddr  out  4  register index = operand[3:0].
- Imm  out  DW  LDI: zero-extended operand; ADDI/BNZ: sign-extended operand; otherwise 0.
- ImmSel  out  1  ALU B operand comes from Imm.
- RegWrite  out  1  one-cycle register-file write strobe.
- MemReq  out  1  memory request, held until MemAck.
- MemWrite  out  1  qualifies MemReq: 1 = store, 0 = load.
- BranchTaken  out  1  one-cycle pulse; fetch adds Imm to its PC.
- Illegal  out  1  sticky; an undefined opcode was seen.
- Done  out  1  high while in HALT.
- RetireCnt  out  CW  retired-instruction count.

Behaviour:
Reset:
- Reset_n=0 at an edge forces state IDLE and clears every output, including Illegal and RetireCnt.
- Reset overrides all other inputs in the same cycle, including mid-MEM; the pending MemReq drops the next cycle.

States: IDLE, DEC, EXE, MEM, WB, HALT.
- IDLE: all strobes 0, InstrReady=0. Start moves to DEC.
- DEC: InstrReady=1. On InstrValid&InstrReady, latch the word and go to:
  - EXE for all ops except LDR/STR and opcode 4'b1111.
  - MEM for LDR/STR.
  - HALT for instr == all ones.
  - EXE for any other opcode 1110/1111, treated as illegal.
  - No transfer: stay in DEC.
- EXE (1 cycle):
  - RegWrite=1 for LSH, RSH, AND, OR, LDI, GEQ, EQ, NEG, ADD, ADDI, NEQ; 0 for BNZ and illegal.
  - ImmSel=1 for LDI, ADDI, BNZ.
  - BNZ: BranchTaken = AccNZ, sampled this cycle.
  - Illegal op: set Illegal, no strobes, not counted.
  - Return to DEC.
- MEM:
  - MemReq=1; MemWrite=1 for STR, 0 for LDR; RegAddr held stable.
  - On MemAck: STR returns to DEC; LDR goes to WB.
  - No timeout; MemAck while not in MEM is ignored.
- WB (1 cycle): RegWrite=1, then DEC.
- HALT: Done=1, InstrReady=0. Start re-enters DEC. Illegal and RetireCnt are held.

Timing and counting:
- Decode latency: a word accepted at edge N drives its strobes in cycle N+1.
- Throughput: 1 instruction per 2 cycles for ALU ops and BNZ; STR takes ≥2 cycles, LDR ≥3.
- RetireCnt increments once per legal instruction at exit from EXE, WB, or MEM (STR only). HALT is counted on entry.
- RetireCnt wraps modulo 2^CW.

Registered outputs:
- AluOp, RegAddr and Imm are registered and hold their last value outside EXE/MEM/WB.
- All strobes are 0 outside their states.
- Start while in DEC/EXE/MEM/WB is ignored.

Test Plan:
- Reset and start: hold Reset_n=0 for 2 cycles → all outputs 0, IDLE. Start pulse → InstrReady=1 the next cycle.
- ADDI: InstrIn=9'b1100_11110 → next cycle AluOp=4'b1100, ImmSel=1, Imm=8'hFE, RegWrite=1 for exactly 1 cycle, RetireCnt=1.
- LDR with 3-cycle ack delay: InstrIn=9'b0101_00011 → MemReq=1, MemWrite=0, RegAddr=3 for 3 cycles. After MemAck, WB RegWrite pulse, then InstrReady=1.
- STR with ack in the first MEM cycle → MemReq for 1 cycle, no RegWrite.
- BNZ: offset 5'b10000 with AccNZ=1 → BranchTaken=1 and Imm=8'hF0. Repeat with AccNZ=0 → BranchTaken=0. RetireCnt increments in both cases.
- Illegal opcode 9'b1110_00000 → Illegal=1 (sticky), no strobes, RetireCnt unchanged.
- HALT: 9'h1FF → Done=1, InstrReady=0. Start → Done=0, DEC.
- Reset mid-MEM → MemReq=0 and IDLE the following cycle.
- RetireCnt wrap: with CW=4, retire 17 instructions → RetireCnt=1.
